// File: rtl/apb_pkg.sv
// Shared types, defaults and the address-legality helper for the APB3 memory completer.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned ADDR_W_DEF = 8;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned WAIT_W     = 4;
   localparam logic [1:0]  ALIGN_MASK = 2'b11;

   // A byte address is legal when it is word aligned and inside the array.
   function automatic logic addr_ok(input logic [31:0] addr, input int unsigned depth);
      return ((addr & 32'(ALIGN_MASK)) == 32'd0) && (addr < depth * 4);
   endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// Loadable down-counter that paces the PREADY-low wait states of an access.
module apb_wait_ctr #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero_c,
   output logic         last_c
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (dec && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign zero_c = (count_q == '0);
   assign last_c = (count_q == W'(1));

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a cleared-on-reset register file, with wait states and PSLVERR.
// Define APB_VIOLATION_CHECK_EN to build the sticky requester protocol-violation checker (viol_o).
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ADDR_W_DEF,
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              PSEL,
   input  logic              PENABLE,
   input  logic              PWRITE,
   input  logic [ADDR_W-1:0] PADDR,
   input  logic [DATA_W-1:0] PWDATA,
   output logic [DATA_W-1:0] PRDATA,
   output logic              PREADY,
   output logic              PSLVERR,
   output logic              viol_o
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   apb_state_e        state_q, state_d, phase_c;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              ctr_zero_c, ctr_last_c;
   logic              setup_c, capture_c, wait_c, finish_c, complete_c;
   logic [ADDR_W-1:0] xfer_addr_c;
   logic              xfer_write_c;
   logic [IDX_W-1:0]  xfer_idx_c;
   logic              bad_c, err_c;

   // SETUP is the requester's setup cycle itself, decoded from the bus while the register
   // sits in IDLE, so the capture lands at its end and a 0-wait transfer takes two cycles.
   assign setup_c    = PSEL && !PENABLE;
   assign phase_c    = (state_q == IDLE && setup_c) ? SETUP : state_q;
   assign capture_c  = (phase_c == SETUP);
   assign wait_c     = (state_q == ACCESS) && !ctr_zero_c;
   assign complete_c = (state_q == ACCESS) && ctr_zero_c;
   assign finish_c   = (capture_c && (WAIT_CYCLES == 0)) || (wait_c && ctr_last_c && PSEL);

   // With no wait states the response is computed straight from the bus during capture.
   assign xfer_addr_c  = (state_q == ACCESS) ? addr_q : PADDR;
   assign xfer_write_c = (state_q == ACCESS) ? write_q : PWRITE;
   assign xfer_idx_c   = IDX_W'(xfer_addr_c[ADDR_W-1:2]);
   assign bad_c        = !addr_ok(32'(xfer_addr_c), DEPTH);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (phase_c)
         IDLE:    state_d = IDLE;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (ctr_zero_c || !PSEL) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   apb_wait_ctr #(.W(WAIT_W)) u_wait_ctr (
      .clk      (PCLK),
      .rst_n    (PRESETn),
      .load     (capture_c),
      .load_val (WAIT_W'(WAIT_CYCLES)),
      .dec      (wait_c),
      .zero_c   (ctr_zero_c),
      .last_c   (ctr_last_c)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         PREADY  <= 1'b0;
         PSLVERR <= 1'b0;
         PRDATA  <= '0;
      end else begin
         if (capture_c) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
         end
         PREADY  <= finish_c;
         PSLVERR <= finish_c && err_c;
         if (finish_c) begin
            if (err_c) begin
               PRDATA <= '0;
            end else if (!xfer_write_c) begin
               PRDATA <= mem[xfer_idx_c];
            end
         end
      end
   end

   // Writes commit at the end of the PREADY cycle, only when no error was signalled.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (complete_c && write_q && !PSLVERR) begin
         mem[IDX_W'(addr_q[ADDR_W-1:2])] <= wdata_q;
      end
   end

`ifdef APB_VIOLATION_CHECK_EN
   logic viol_now_c;
   logic viol_xfer_q;

   assign viol_now_c = (wait_c && PSEL && ((PADDR != addr_q) || (PWRITE != write_q) ||
                                           (PWDATA != wdata_q) || !PENABLE))
                     || ((state_q == IDLE) && PSEL && PENABLE);
   assign err_c      = bad_c || ((state_q == ACCESS) && (viol_xfer_q || viol_now_c));

   // viol_o is sticky until reset; viol_xfer_q only poisons the transfer in flight.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         viol_o      <= 1'b0;
         viol_xfer_q <= 1'b0;
      end else begin
         viol_o      <= viol_o || viol_now_c;
         viol_xfer_q <= capture_c ? 1'b0 : (viol_xfer_q || (wait_c && viol_now_c));
      end
   end
`else
   assign err_c  = bad_c;
   assign viol_o = 1'b0;
`endif

endmodule
